uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Captures each byte presented with the receiver's single-cycle done strobe into a circular FIFO.
- Presents bytes to the host/bus side through a registered read port.
- Reports fill level, full/empty and a sticky overflow flag so bytes arriving faster than the consumer drains them are detected, not silently lost.

---
 rtl/uart_rx_fifo.sv | 69 ++++++
 tb/tb_uart_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer between a UART receiver and the host read port.
// Ports:
//   clk, reset                 - system clock; asynchronous active-high reset
//   wr_data, wr_tick           - received character and its one-cycle done strobe
//   rd_en                      - consumer request, one entry per asserted cycle
//   rd_data, rd_valid          - registered read data and its one-cycle valid pulse
//   empty, full, count         - fill status derived from the registered entry count
//   overflow, ovf_clr          - sticky dropped-write flag and its clear
// Optional macro UART_RX_FIFO_LEVEL_EN adds level_thresh (in) and level_irq (out):
//   level_irq is high while the stored count is at or above a non-zero threshold.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_tick,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   count,
`ifdef UART_RX_FIFO_LEVEL_EN
  input  logic [ADDR_BITS:0]   level_thresh,
  output logic                 level_irq,
`endif
  output logic                 overflow,
  input  logic                 ovf_clr
);
  localparam int DEPTH = 1 << ADDR_BITS;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count_nxt;
  logic                 rd_acc, wr_acc, drop;
  assign empty = count == '0;
  assign full  = count == (ADDR_BITS+1)'(DEPTH);
  // A read in the same cycle frees a slot, so a write to a full FIFO is still taken.
  assign rd_acc    = rd_en & ~empty;
  assign wr_acc    = wr_tick & (~full | rd_acc);
  assign drop      = wr_tick & ~wr_acc;
  assign count_nxt = count + (ADDR_BITS+1)'(wr_acc) - (ADDR_BITS+1)'(rd_acc);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_BITS'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= rd_acc;
      count    <= count_nxt;
      overflow <= drop | (overflow & ~ovf_clr);
    end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
`ifdef UART_RX_FIFO_LEVEL_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) level_irq <= 1'b0;
    else level_irq <= (count_nxt >= level_thresh) && (level_thresh != '0);
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_tick = 1'b0;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, overflow;
  logic [4:0] count;
  logic [4:0] level_thresh = '0;
  logic       level_irq;
  int         errors = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.DATA_BITS(8), .ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_tick(wr_tick), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
`ifdef UART_RX_FIFO_LEVEL_EN
    .level_thresh(level_thresh), .level_irq(level_irq),
`endif
    .overflow(overflow), .ovf_clr(ovf_clr)
  );
`ifndef UART_RX_FIFO_LEVEL_EN
  assign level_irq = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] b);
    wr_data = b;
    wr_tick = 1'b1;
    step();
    wr_tick = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic       ra, wa;
    step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    reset = 1'b0;
    step();
    wr(8'h41); wr(8'h42); wr(8'h43);
    chk("abc_count3", count, 3);
    chk("abc_empty0", empty, 0);
    rd_en = 1'b1;
    step();
    chk("abc_v1", rd_valid, 1); chk("abc_d1", rd_data, 8'h41); chk("abc_c2", count, 2);
    step();
    chk("abc_v2", rd_valid, 1); chk("abc_d2", rd_data, 8'h42);
    step();
    rd_en = 1'b0;
    chk("abc_v3", rd_valid, 1); chk("abc_d3", rd_data, 8'h43);
    chk("abc_count0", count, 0);
    chk("abc_empty1", empty, 1);
    step();
    chk("abc_vlow", rd_valid, 0);
    chk("abc_hold", rd_data, 8'h43);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("under_valid", rd_valid, 0);
    chk("under_count", count, 0);
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    wr(8'hFF);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) rd("ovf_rd", 8'(i));
    chk("ovf_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 16; i++) wr(8'(i));
    ovf_clr = 1'b1;
    wr(8'h77);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    wr_data = 8'hAA; wr_tick = 1'b1; rd_en = 1'b1;
    step();
    wr_tick = 1'b0; rd_en = 1'b0;
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_count", count, 16);
    chk("fullrw_valid", rd_valid, 1);
    chk("fullrw_data", rd_data, 8'h00);
    for (int i = 1; i < 16; i++) rd("fullrw_rd", 8'(i));
    rd("fullrw_last", 8'hAA);
    chk("fullrw_empty", empty, 1);
    wr_data = 8'h55; wr_tick = 1'b1; rd_en = 1'b1;
    step();
    wr_tick = 1'b0; rd_en = 1'b0;
    chk("emptyrw_valid", rd_valid, 0);
    chk("emptyrw_count", count, 1);
    rd("emptyrw_rd", 8'h55);
    for (int i = 0; i < 40; i++) begin
      ra = (i % 3 != 0) && q.size() > 0;
      wa = q.size() < 16 || ra;
      exp_b = ra ? q[0] : 8'h00;
      if (ra) q.pop_front();
      if (wa) q.push_back(8'(i * 7 + 3));
      wr_data = 8'(i * 7 + 3); wr_tick = 1'b1; rd_en = (i % 3 != 0);
      step();
      wr_tick = 1'b0; rd_en = 1'b0;
      if (ra) chk("wrap_data", rd_data, exp_b);
      chk("wrap_valid", rd_valid, ra);
      chk("wrap_count", count, q.size());
    end
    for (int i = 0; i < 20; i++) wr(8'hC0);
    chk("pre_rst_full", full, 1);
    chk("pre_rst_ovf", overflow, 1);
    reset = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_ovf", overflow, 0);
    chk("async_full", full, 0);
    step();
    reset = 1'b0;
    step();
    wr(8'h11);
    rd("post_rst_rd", 8'h11);
`ifdef UART_RX_FIFO_LEVEL_EN
    level_thresh = 5'd4;
    wr(8'h01); wr(8'h02); wr(8'h03);
    chk("lvl_below", level_irq, 0);
    wr(8'h04);
    chk("lvl_rise", level_irq, 1);
    rd("lvl_rd", 8'h01);
    chk("lvl_fall", level_irq, 0);
    level_thresh = 5'd0;
    wr(8'h05); wr(8'h06);
    chk("lvl_zero", level_irq, 0);
    do_reset();
    chk("lvl_rst", level_irq, 0);
`else
    do_reset();
`endif
    chk("end_empty", empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
